// File: rtl/aes_key_schedule_gen.sv
// aes_key_schedule_gen: iterative AES-128/192/256 key expansion (one word per clock) with a registered round-key read port.
// Optional feature macro: AES_KEY_SCHED_DEC_ORDER_EN enables decryption-order reads selected by rd_dec.

// aes_sbox: combinational AES S-box computed as GF(2^8) inverse followed by the affine map
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] r;
        logic [7:0] v;
        r = 8'h00;
        v = x;
        for (int k = 0; k < 8; k++) begin
            if (y[k]) r = r ^ v;
            v = {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
        end
        return r;
    endfunction

    logic [7:0] a2, a3, a6, a7, a14, a15, a30, a31, a62, a63, a126, a127, inv;

    // a^254 is the multiplicative inverse, and maps 0 to 0 as the S-box requires
    assign a2   = gmul(a, a);
    assign a3   = gmul(a2, a);
    assign a6   = gmul(a3, a3);
    assign a7   = gmul(a6, a);
    assign a14  = gmul(a7, a7);
    assign a15  = gmul(a14, a);
    assign a30  = gmul(a15, a15);
    assign a31  = gmul(a30, a);
    assign a62  = gmul(a31, a31);
    assign a63  = gmul(a62, a);
    assign a126 = gmul(a63, a63);
    assign a127 = gmul(a126, a);
    assign inv  = gmul(a127, a127);
    assign s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module aes_key_schedule_gen #(
    parameter int MAX_WORDS = 60
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   mode,
    input  logic [255:0] key_in,
    input  logic         key_load,
    input  logic [3:0]   rd_round,
    input  logic [1:0]   rd_word,
    input  logic         rd_dec,
    output logic         key_busy,
    output logic         key_ready,
    output logic [31:0]  rk_word
);
    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

    state_t      state;
    logic [1:0]  mode_q, mode_in;
    logic [5:0]  i;
    logic [2:0]  p;
    logic [7:0]  rcon;
    logic [31:0] w [MAX_WORDS];
    logic [3:0]  nk;
    logic [6:0]  t_words, ra;
    logic [31:0] prev, old, sub_in, sub_out, tmp, nxt;
    logic        load_ok, last;

    assign mode_in = (mode == 2'b11) ? 2'b00 : mode;
    assign nk      = mode_q == 2'b10 ? 4'd8  : mode_q == 2'b01 ? 4'd6  : 4'd4;
    assign t_words = mode_q == 2'b10 ? 7'd60 : mode_q == 2'b01 ? 7'd52 : 7'd44;
    assign load_ok = key_load && state != EXPAND;
    assign last    = {1'b0, i} == t_words - 7'd1;

    assign prev   = w[i - 6'd1];
    assign old    = w[i - {2'b00, nk}];
    assign sub_in = p == 3'd0 ? {prev[23:0], prev[31:24]} : prev;

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (.a(sub_in[8*g +: 8]), .s(sub_out[8*g +: 8]));
    end

    assign tmp = p == 3'd0 ? sub_out ^ {rcon, 24'h0} : (nk == 4'd8 && p == 3'd4) ? sub_out : prev;
    assign nxt = old ^ tmp;

`ifdef AES_KEY_SCHED_DEC_ORDER_EN
    logic [3:0] nr;
    assign nr = mode_q == 2'b10 ? 4'd14 : mode_q == 2'b01 ? 4'd12 : 4'd10;
    // rounds beyond Nr wrap negative into the high 7-bit range and so read as out of range
    assign ra = rd_dec ? {1'b0, nr, 2'b00} - {1'b0, rd_round, 2'b00} + {5'b0, rd_word}
                       : {1'b0, rd_round, 2'b00} + {5'b0, rd_word};
`else
    logic unused_rd_dec;
    assign unused_rd_dec = rd_dec;
    assign ra = {1'b0, rd_round, 2'b00} + {5'b0, rd_word};
`endif

    // control FSM: load latches the key size, then one schedule word per cycle until w[T-1]
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            key_busy  <= 1'b0;
            key_ready <= 1'b0;
            mode_q    <= 2'b00;
            i         <= 6'd0;
            p         <= 3'd0;
            rcon      <= 8'h01;
        end else if (load_ok) begin
            state     <= EXPAND;
            key_busy  <= 1'b1;
            key_ready <= 1'b0;
            mode_q    <= mode_in;
            i         <= mode_in == 2'b10 ? 6'd8 : mode_in == 2'b01 ? 6'd6 : 6'd4;
            p         <= 3'd0;
            rcon      <= 8'h01;
        end else if (state == EXPAND) begin
            i    <= i + 6'd1;
            p    <= ({1'b0, p} == nk - 4'd1) ? 3'd0 : p + 3'd1;
            rcon <= p == 3'd0 ? {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00) : rcon;
            if (last) begin
                state     <= READY;
                key_busy  <= 1'b0;
                key_ready <= 1'b1;
            end
        end
    end

    // schedule store: key words on load, one expanded word per EXPAND cycle; never cleared
    always_ff @(posedge clk) begin
        if (!reset && load_ok) begin
            w[0] <= key_in[255:224];
            w[1] <= key_in[223:192];
            w[2] <= key_in[191:160];
            w[3] <= key_in[159:128];
            if (mode_in != 2'b00) begin
                w[4] <= key_in[127:96];
                w[5] <= key_in[95:64];
            end
            if (mode_in == 2'b10) begin
                w[6] <= key_in[63:32];
                w[7] <= key_in[31:0];
            end
        end else if (!reset && state == EXPAND) begin
            w[i] <= nxt;
        end
    end

    // registered read port; addresses past the latched schedule length read as zero
    always_ff @(posedge clk) begin
        if (reset) rk_word <= 32'h0;
        else       rk_word <= ra < t_words ? w[ra[5:0]] : 32'h0;
    end
endmodule
